// File: rtl/sopc_spi_slave_pkg.sv
// Shared definitions for the SPI slave endpoint: register map, status/control
// bit positions (identical to the SPI master) and the frame state type.
package sopc_spi_slave_pkg;

  // Register addresses on the CPU bus
  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  // Status bit positions; interrupt enables sit at the same positions in control
  localparam int BIT_E    = 8;
  localparam int BIT_RRDY = 7;
  localparam int BIT_TRDY = 6;
  localparam int BIT_TMT  = 5;
  localparam int BIT_TOE  = 4;
  localparam int BIT_ROE  = 3;

  // Writable control bits: iE, iRRDY, iTRDY, iTOE, iROE
  localparam logic [15:0] CTRL_MASK = 16'h01D8;

  // Frame state: IDLE while SS_n is high, ACTIVE while selected
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a selectable
// reset value so an idle line does not look like an edge after reset.
module spi_slave_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the raw pin through the chain; the last flop is the usable sample
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/sopc_spi_slave.sv
// SPI slave endpoint (CPOL 0, CPHA 0, MSB first) with the same memory-mapped
// register layout as the SPI master. All SPI pins are oversampled by clk.
module sopc_spi_slave
  import sopc_spi_slave_pkg::*;
#(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  // Synchronized pins and their previous samples for edge detection
  logic sclkSync, ssnSync, mosiSync;
  logic sclkPrev_q, ssnPrev_q;
  logic sclkRise, sclkFall, ssFall, ssRise;

  // Bus strobes
  logic rdStrobePrev_q, wrStrobePrev_q;
  logic rdStrobe, wrStrobe;

  // Frame FSM and the events it hands to the datapath
  spi_state_e state_q, state_d;
  logic startFrame, endFrame, rxSample, txEdge, frameActive;

  // Datapath registers
  logic [2:0]          bitCnt_q, bitCnt_d;
  logic [DATABITS-1:0] rxShift_q, rxShift_d;
  logic [DATABITS-1:0] rxHolding_q, rxHolding_d;
  logic [DATABITS-1:0] txShift_q, txShift_d;
  logic [DATABITS-1:0] txHolding_q, txHolding_d;
  logic                txPrimed_q, txPrimed_d;
  logic                reloadPending_q, reloadPending_d;
  logic                rrdy_q, rrdy_d;
  logic                roe_q, roe_d;
  logic                toe_q, toe_d;
  logic [15:0]         ctrl_q, ctrl_d;
  logic [15:0]         rdData_q, rdData_d;
  logic                irq_q, irq_d;
  logic [15:0]         statusWord;
  logic                byteDone, txLoad;
  logic [DATABITS-1:0] rxNext;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk), .rst_ni(reset_n), .d_i(SCLK), .q_o(sclkSync)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ssn (
    .clk_i(clk), .rst_ni(reset_n), .d_i(SS_n), .q_o(ssnSync)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk), .rst_ni(reset_n), .d_i(MOSI), .q_o(mosiSync)
  );

  assign sclkRise = sclkSync & ~sclkPrev_q;
  assign sclkFall = ~sclkSync & sclkPrev_q;
  assign ssFall   = ~ssnSync & ssnPrev_q;
  assign ssRise   = ssnSync & ~ssnPrev_q;

  // A held strobe fires only on its first cycle of a two-cycle access
  assign rdStrobe = spi_select & ~read_n & ~rdStrobePrev_q;
  assign wrStrobe = spi_select & ~write_n & ~wrStrobePrev_q;

  // Remember previous pin samples and strobes for edge/first-cycle detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclkPrev_q     <= 1'b0;
      ssnPrev_q      <= 1'b1;
      rdStrobePrev_q <= 1'b0;
      wrStrobePrev_q <= 1'b0;
    end else begin
      sclkPrev_q     <= sclkSync;
      ssnPrev_q      <= ssnSync;
      rdStrobePrev_q <= rdStrobe;
      wrStrobePrev_q <= wrStrobe;
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame state transitions follow the synchronized slave select
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ssFall) state_d = ACTIVE;
      ACTIVE:  if (ssRise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame events for the datapath; deselect wins over a coincident SCLK edge
  always_comb begin
    startFrame  = 1'b0;
    endFrame    = 1'b0;
    rxSample    = 1'b0;
    txEdge      = 1'b0;
    frameActive = 1'b0;
    case (state_q)
      IDLE: begin
        startFrame = ssFall;
      end
      ACTIVE: begin
        frameActive = 1'b1;
        endFrame    = ssRise;
        rxSample    = sclkRise & ~ssRise;
        txEdge      = sclkFall & ~ssRise;
      end
      default: ;
    endcase
  end

  // Status word assembled from live flags
  always_comb begin
    statusWord           = '0;
    statusWord[BIT_E]    = roe_q | toe_q;
    statusWord[BIT_RRDY] = rrdy_q;
    statusWord[BIT_TRDY] = ~txPrimed_q;
    statusWord[BIT_TMT]  = ~frameActive & ~txPrimed_q;
    statusWord[BIT_TOE]  = toe_q;
    statusWord[BIT_ROE]  = roe_q;
  end

  assign byteDone = rxSample && (bitCnt_q == 3'(DATABITS - 1));
  assign txLoad   = startFrame | (txEdge & reloadPending_q);
  assign rxNext   = {rxShift_q[DATABITS-2:0], mosiSync};

  // Shift registers, flags and bus side effects; byte completion beats clears
  always_comb begin
    bitCnt_d        = bitCnt_q;
    rxShift_d       = rxShift_q;
    rxHolding_d     = rxHolding_q;
    txShift_d       = txShift_q;
    txHolding_d     = txHolding_q;
    txPrimed_d      = txPrimed_q;
    reloadPending_d = reloadPending_q;
    rrdy_d          = rrdy_q;
    roe_d           = roe_q;
    toe_d           = toe_q;
    ctrl_d          = ctrl_q;
    rdData_d        = rdData_q;

    if (startFrame || endFrame) begin
      bitCnt_d        = '0;
      reloadPending_d = 1'b0;
    end

    if (rxSample) begin
      rxShift_d = rxNext;
      bitCnt_d  = bitCnt_q + 3'd1;
    end

    if (txLoad) begin
      txShift_d       = txPrimed_q ? txHolding_q : '0;
      txPrimed_d      = 1'b0;
      reloadPending_d = 1'b0;
    end else if (txEdge) begin
      txShift_d = {txShift_q[DATABITS-2:0], 1'b0};
    end

    if (wrStrobe) begin
      case (mem_addr)
        ADDR_TXDATA: begin
          if (!txPrimed_q) begin
            txHolding_d = data_from_cpu[DATABITS-1:0];
            txPrimed_d  = 1'b1;
          end else begin
            toe_d = 1'b1;
          end
        end
        ADDR_STATUS: begin
          rrdy_d = 1'b0;
          roe_d  = 1'b0;
          toe_d  = 1'b0;
        end
        ADDR_CONTROL: ctrl_d = data_from_cpu & CTRL_MASK;
        default: ;
      endcase
    end

    if (rdStrobe) begin
      case (mem_addr)
        ADDR_RXDATA: begin
          rdData_d = 16'(rxHolding_q);
          rrdy_d   = 1'b0;
        end
        ADDR_STATUS:  rdData_d = statusWord;
        ADDR_CONTROL: rdData_d = ctrl_q;
        default:      rdData_d = '0;
      endcase
    end

    if (byteDone) begin
      rxHolding_d     = rxNext;
      rrdy_d          = 1'b1;
      bitCnt_d        = '0;
      reloadPending_d = 1'b1;
      if (rrdy_q) roe_d = 1'b1;
    end
  end

  // Enable bits share positions with status bits, so a bitwise AND gives irq
  assign irq_d = |(statusWord & ctrl_q);

  // Datapath register bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitCnt_q        <= '0;
      rxShift_q       <= '0;
      rxHolding_q     <= '0;
      txShift_q       <= '0;
      txHolding_q     <= '0;
      txPrimed_q      <= 1'b0;
      reloadPending_q <= 1'b0;
      rrdy_q          <= 1'b0;
      roe_q           <= 1'b0;
      toe_q           <= 1'b0;
      ctrl_q          <= '0;
      rdData_q        <= '0;
      irq_q           <= 1'b0;
    end else begin
      bitCnt_q        <= bitCnt_d;
      rxShift_q       <= rxShift_d;
      rxHolding_q     <= rxHolding_d;
      txShift_q       <= txShift_d;
      txHolding_q     <= txHolding_d;
      txPrimed_q      <= txPrimed_d;
      reloadPending_q <= reloadPending_d;
      rrdy_q          <= rrdy_d;
      roe_q           <= roe_d;
      toe_q           <= toe_d;
      ctrl_q          <= ctrl_d;
      rdData_q        <= rdData_d;
      irq_q           <= irq_d;
    end
  end

  assign MISO          = frameActive & txShift_q[DATABITS-1];
  assign MISO_oe       = ~ssnSync;
  assign data_to_cpu   = rdData_q;
  assign irq           = irq_q;
  assign dataavailable = rrdy_q;
  assign readyfordata  = ~txPrimed_q;

endmodule
